// File: rtl/gs_bt_unit.sv
// Gentleman-Sande inverse-NTT butterfly: A' = (A+B) mod Q, B' = ((A-B)*zeta) mod Q,
// with an optional 2^-1 mod Q scale. Four-stage pipeline, one pair per cycle.
module gs_bt_unit #(
   parameter int bit_len = 13,
   parameter int Q       = 7681
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [bit_len-1:0] A_in,
   input  logic [bit_len-1:0] B_in,
   input  logic [bit_len-1:0] zeta,
   input  logic               halve,
   output logic [bit_len-1:0] A_out,
   output logic [bit_len-1:0] B_out,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               busy
);

   localparam int W = bit_len;
   localparam logic [W:0]     L_Q1 = (W+1)'(Q);
   localparam logic [2*W-1:0] L_Q2 = (2*W)'(Q);

   // Handshake: a pair moves in on in_valid & in_ready and out on out_valid & out_ready,
   // both at a rising edge. The whole pipe freezes (bubbles included) while the output
   // holds a pair that downstream refuses, so in_ready is simply the inverse of that stall.
   logic w_stall;

   logic           r_v1, r_v2, r_v3, r_v4;
   logic [W:0]     r_sum1, r_diff1;
   logic [W-1:0]   r_z1, r_z2;
   logic           r_h1, r_h2, r_h3, r_h4;
   logic [W-1:0]   r_sum2, r_diff2;
   logic [W-1:0]   r_sum3;
   logic [2*W-1:0] r_prod3;
   logic [W-1:0]   r_a4, r_b4;

   logic [W:0]     w_sum1, w_diff1;
   logic [W-1:0]   w_sum2, w_diff2;
   logic [W-1:0]   w_mod;

   // x * 2^-1 mod Q: Q is odd, so an odd x becomes even after adding Q.
   function automatic logic [W-1:0] half_mod(input logic [W-1:0] x);
      logic [W:0] t;
      t = x[0] ? ({1'b0, x} + L_Q1) : {1'b0, x};
      return W'(t >> 1);
   endfunction

   assign w_stall   = r_v4 & ~out_ready;
   assign in_ready  = ~w_stall;
   assign out_valid = r_v4;
   assign busy      = r_v1 | r_v2 | r_v3 | r_v4;
   assign A_out     = r_a4;
   assign B_out     = r_b4;

   // Adding Q before subtracting keeps the difference non-negative (1..2Q-1).
   assign w_sum1  = {1'b0, A_in} + {1'b0, B_in};
   assign w_diff1 = {1'b0, A_in} + L_Q1 - {1'b0, B_in};

   assign w_sum2  = (r_sum1  >= L_Q1) ? W'(r_sum1  - L_Q1) : r_sum1[W-1:0];
   assign w_diff2 = (r_diff1 >= L_Q1) ? W'(r_diff1 - L_Q1) : r_diff1[W-1:0];

   assign w_mod   = W'(r_prod3 % L_Q2);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
         r_v3 <= 1'b0;
         r_v4 <= 1'b0;
         r_a4 <= '0;
         r_b4 <= '0;
      end else if (!w_stall) begin
         r_v1    <= in_valid;
         r_sum1  <= w_sum1;
         r_diff1 <= w_diff1;
         r_z1    <= zeta;
         r_h1    <= halve;

         r_v2    <= r_v1;
         r_sum2  <= w_sum2;
         r_diff2 <= w_diff2;
         r_z2    <= r_z1;
         r_h2    <= r_h1;

         r_v3    <= r_v2;
         r_sum3  <= r_sum2;
         r_prod3 <= {{W{1'b0}}, r_diff2} * {{W{1'b0}}, r_z2};
         r_h3    <= r_h2;

         // Output registers only load real pairs so they keep their last value otherwise.
         r_v4 <= r_v3;
         if (r_v3) begin
            r_h4 <= r_h3;
            r_a4 <= r_h3 ? half_mod(r_sum3) : r_sum3;
            r_b4 <= r_h3 ? half_mod(w_mod)  : w_mod;
         end
      end
   end

endmodule
